tcdm_rr_mux: RTL and testbench
==============================

TCDM_RR_MUX -- requirements
Module: tcdm_rr_mux

Interface
REQ-001 SHALL have parameter MP, default 3, meaning number of TCDM master ports merged (the accelerator's tcdm_* ports).
REQ-002 SHALL have parameter OUTST, default 4, meaning maximum outstanding granted transactions (ID FIFO depth, power of two, >=2).
REQ-003 SHALL have port clk_i  input  1  clock; all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-005 SHALL have port clear_i  input  1  synchronous clear of all state, same effect as reset.
REQ-006 SHALL have ports mst_req/mst_wen  input  [MP-1:0]  per-master request / write-enable (wen=1 read, wen=0 write).
REQ-007 SHALL have ports mst_add/mst_data  input  [MP-1:0][31:0]  per-master address / write data; mst_be input [MP-1:0][3:0] byte enables.
REQ-008 SHALL have ports mst_gnt/mst_r_valid  output  [MP-1:0]  per-master grant / response valid; mst_r_data output [MP-1:0][31:0].
REQ-009 SHALL have ports slv_req/slv_wen  output  1, slv_add/slv_data  output  32, slv_be  output  4  memory-side request.
REQ-010 SHALL have ports slv_gnt/slv_r_valid  input  1, slv_r_data  input  32  memory-side grant / response.
REQ-011 SHALL have port err_o  output  1  sticky protocol error flag.

Function
REQ-012 SHALL select at most one requesting master per cycle by round-robin: search starts at (last_granted+1) mod MP, wraps at MP-1 -> 0.
REQ-013 SHALL drive slv_req=1 and forward the selected master's add/wen/be/data combinationally when any mst_req=1 and ID FIFO not full; otherwise slv_req=0, other slv_* outputs 0.
REQ-014 SHALL assert mst_gnt[i]=slv_gnt & slv_req & (selected==i) in the same cycle (zero-cycle grant path); all other mst_gnt=0.
REQ-015 SHALL update last_granted to the selected index only on a cycle where slv_req & slv_gnt; refused requests do not advance the pointer.
REQ-016 SHALL keep the selection stable while slv_req=1 and slv_gnt=0, even if higher-priority masters raise req meanwhile.
REQ-017 SHALL push the granted master index into an in-order ID FIFO on every handshake, reads and writes alike.
REQ-018 SHALL, on slv_r_valid=1, pop the FIFO head and assert mst_r_valid[head]=1 with mst_r_data[head]=slv_r_data in the same cycle; other masters r_valid=0, r_data=0.
REQ-019 SHALL support simultaneous push and pop in one cycle, including when full (pop frees the slot: grant allowed) and when empty (pop of empty is an error).
REQ-020 SHALL set err_o=1 on slv_r_valid while FIFO empty; err_o stays 1 until reset/clear; that response is dropped.
REQ-021 SHALL block new grants (slv_req=0) while OUTST transactions are outstanding and no pop occurs that cycle.
REQ-022 SHALL add no latency: request path combinational, response path combinational; only pointer, FIFO and err_o are registered.

Reset
REQ-023 SHALL on rst_ni=0 (asynchronous) or clear_i=1 (synchronous) set last_granted=MP-1 (master 0 first priority), FIFO empty, err_o=0.
REQ-024 SHALL, during reset, drive all mst_gnt, mst_r_valid, slv_req low; transactions in flight at reset are discarded and their later responses flag err_o.

Structure
REQ-025 SHALL use log2(MP) index width and FIFO pointer width from a shared package (tcdm_rr_mux_package) along with the default MP/OUTST constants.
REQ-026 SHALL implement the ID FIFO as sub-module tcdm_rr_mux_id_fifo (depth OUTST, width log2(MP), push/pop/full/empty, first-word fall-through).

Verification
REQ-027 SHALL check: all 3 masters req continuously, slv_gnt=1, 1-cycle memory -> grants 0,1,2,0,1,2 on consecutive cycles; each r_data routed to its own master.
REQ-028 SHALL check: master 2 alone reads 0x100 with slv_gnt held 0 for 3 cycles, master 0 raises req in cycle 2 -> master 2 granted first, then master 0.
REQ-029 SHALL check: memory stalls responses, 4 grants issued -> 5th request sees slv_req=0; a response with simultaneous request in the same cycle -> grant allowed.
REQ-030 SHALL check: slv_r_valid pulsed with FIFO empty -> err_o=1 persistently, no mst_r_valid asserted; clear_i=1 -> err_o=0.
REQ-031 SHALL check: rst_ni low mid-burst with 2 outstanding -> outputs low immediately, pointer restarts at master 0 after release.

Source files
------------

// File: rtl/tcdm_rr_mux_pkg.sv
// Shared constants and width helpers for the TCDM round-robin multiplexer.
package tcdm_rr_mux_package;

    localparam int unsigned MP_DEFAULT    = 3;
    localparam int unsigned OUTST_DEFAULT = 4;

    // Index width that never collapses to zero bits for single-entry sizes.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned IDX_W_DEFAULT = idx_width(MP_DEFAULT);
    localparam int unsigned PTR_W_DEFAULT = idx_width(OUTST_DEFAULT);

endpackage

// File: rtl/tcdm_rr_mux_id_fifo.sv
// In-order FIFO of granted master indices, first-word fall-through.
module tcdm_rr_mux_id_fifo
    import tcdm_rr_mux_package::*;
#(
    parameter int unsigned DEPTH = OUTST_DEFAULT,
    parameter int unsigned WIDTH = IDX_W_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PTR_W = idx_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_cnt;
    logic             w_pop;
    logic             w_push;

    assign o_full  = (r_cnt == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_data  = r_mem[r_rptr];

    // A pop in the same cycle frees a slot, so a push into a full FIFO is legal then.
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (clear_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/tcdm_rr_mux.sv
// Round-robin merge of MP TCDM master ports onto one memory port, responses routed in order.
module tcdm_rr_mux
    import tcdm_rr_mux_package::*;
#(
    parameter int unsigned MP    = MP_DEFAULT,
    parameter int unsigned OUTST = OUTST_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic [MP-1:0]        mst_req,
    input  logic [MP-1:0]        mst_wen,
    input  logic [MP-1:0][31:0]  mst_add,
    input  logic [MP-1:0][31:0]  mst_data,
    input  logic [MP-1:0][3:0]   mst_be,
    output logic [MP-1:0]        mst_gnt,
    output logic [MP-1:0]        mst_r_valid,
    output logic [MP-1:0][31:0]  mst_r_data,
    output logic                 slv_req,
    output logic                 slv_wen,
    output logic [31:0]          slv_add,
    output logic [31:0]          slv_data,
    output logic [3:0]           slv_be,
    input  logic                 slv_gnt,
    input  logic                 slv_r_valid,
    input  logic [31:0]          slv_r_data,
    output logic                 err_o
);

    localparam int unsigned IDX_W = idx_width(MP);

    logic [IDX_W-1:0] r_last;
    logic [IDX_W-1:0] r_lock_idx;
    logic             r_lock;
    logic             r_err;

    logic [IDX_W-1:0] w_sel;
    logic [IDX_W:0]   w_cand;
    logic             w_found;
    logic [IDX_W-1:0] w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_hs;

    // A refused request keeps its selection until granted, even against higher priority.
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        if (r_lock && mst_req[r_lock_idx]) begin
            w_sel   = r_lock_idx;
            w_found = 1'b1;
        end else begin
            for (int unsigned k = 1; k <= MP; k++) begin
                w_cand = {1'b0, r_last} + (IDX_W+1)'(k);
                if (w_cand >= (IDX_W+1)'(MP)) w_cand = w_cand - (IDX_W+1)'(MP);
                if (!w_found && mst_req[w_cand[IDX_W-1:0]]) begin
                    w_found = 1'b1;
                    w_sel   = w_cand[IDX_W-1:0];
                end
            end
        end
    end

    assign w_pop   = rst_ni & slv_r_valid & ~w_empty;
    assign slv_req = rst_ni & w_found & (~w_full | w_pop);
    assign w_hs    = slv_req & slv_gnt;
    assign err_o   = r_err;

    always_comb begin
        slv_wen     = 1'b0;
        slv_add     = '0;
        slv_data    = '0;
        slv_be      = '0;
        mst_gnt     = '0;
        mst_r_valid = '0;
        mst_r_data  = '0;
        if (slv_req) begin
            slv_wen        = mst_wen[w_sel];
            slv_add        = mst_add[w_sel];
            slv_data       = mst_data[w_sel];
            slv_be         = mst_be[w_sel];
            mst_gnt[w_sel] = slv_gnt;
        end
        if (w_pop) begin
            mst_r_valid[w_head] = 1'b1;
            mst_r_data[w_head]  = slv_r_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_last     <= IDX_W'(MP - 1);
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
            r_err      <= 1'b0;
        end else if (clear_i) begin
            r_last     <= IDX_W'(MP - 1);
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_hs) r_last <= w_sel;
            r_lock <= slv_req & ~slv_gnt;
            if (slv_req & ~slv_gnt) r_lock_idx <= w_sel;
            if (slv_r_valid & w_empty) r_err <= 1'b1;
        end
    end

    tcdm_rr_mux_id_fifo #(
        .DEPTH (OUTST),
        .WIDTH (IDX_W)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .i_push  (w_hs),
        .i_data  (w_sel),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

// File: tb/tb_tcdm_rr_mux.sv
// Directed and randomized bench for tcdm_rr_mux against a queue-based reference model.
module tb_tcdm_rr_mux;

    localparam int MP    = 3;
    localparam int OUTST = 4;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic              clear_i;
    logic [MP-1:0]     mst_req, mst_wen;
    logic [MP-1:0][31:0] mst_add, mst_data;
    logic [MP-1:0][3:0]  mst_be;
    logic [MP-1:0]     mst_gnt, mst_r_valid;
    logic [MP-1:0][31:0] mst_r_data;
    logic              slv_req, slv_wen;
    logic [31:0]       slv_add, slv_data;
    logic [3:0]        slv_be;
    logic              slv_gnt, slv_r_valid;
    logic [31:0]       slv_r_data;
    logic              err_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int q[$];
    int last;
    int held;
    bit m_err;
    bit m_hs;

    logic [MP-1:0] obs_gnt;
    logic          obs_req;
    logic [31:0]   obs_add;

    always #5 clk = ~clk;

    tcdm_rr_mux #(.MP(MP), .OUTST(OUTST)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i),
        .mst_req(mst_req), .mst_wen(mst_wen), .mst_add(mst_add),
        .mst_data(mst_data), .mst_be(mst_be),
        .mst_gnt(mst_gnt), .mst_r_valid(mst_r_valid), .mst_r_data(mst_r_data),
        .slv_req(slv_req), .slv_wen(slv_wen), .slv_add(slv_add),
        .slv_data(slv_data), .slv_be(slv_be),
        .slv_gnt(slv_gnt), .slv_r_valid(slv_r_valid), .slv_r_data(slv_r_data),
        .err_o(err_o)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        last  = MP - 1;
        held  = -1;
        m_err = 0;
        m_hs  = 0;
    endtask

    // Called at a falling edge with inputs already applied; returns at the next falling edge.
    task automatic step();
        logic [MP-1:0]       e_gnt, e_rv;
        logic [MP-1:0][31:0] e_rd;
        logic [31:0] e_add, e_dat;
        logic [3:0]  e_be;
        logic        e_wen, e_req;
        int n, sel;
        bit full, pop;
        #1;
        n    = q.size();
        full = (n == OUTST);
        pop  = slv_r_valid && (n > 0);
        sel  = -1;
        if (held >= 0 && mst_req[held]) sel = held;
        else begin
            for (int k = 1; k <= MP; k++) begin
                int c;
                c = (last + k) % MP;
                if (sel < 0 && mst_req[c]) sel = c;
            end
        end
        e_req = (sel >= 0) && (!full || pop);
        e_gnt = '0; e_add = '0; e_dat = '0; e_be = '0; e_wen = 1'b0;
        if (e_req) begin
            e_add = mst_add[sel];
            e_dat = mst_data[sel];
            e_be  = mst_be[sel];
            e_wen = mst_wen[sel];
            if (slv_gnt) e_gnt[sel] = 1'b1;
        end
        e_rv = '0; e_rd = '0;
        if (pop) begin
            e_rv[q[0]] = 1'b1;
            e_rd[q[0]] = slv_r_data;
        end
        chk("slv_req", slv_req, e_req);
        chk("slv_add", slv_add, e_add);
        chk("slv_data", slv_data, e_dat);
        chk("slv_be", slv_be, e_be);
        chk("slv_wen", slv_wen, e_wen);
        chk("mst_gnt", mst_gnt, e_gnt);
        chk("mst_r_valid", mst_r_valid, e_rv);
        chk("mst_r_data", mst_r_data, e_rd);
        chk("err_o", err_o, m_err);
        obs_gnt = mst_gnt;
        obs_req = slv_req;
        obs_add = slv_add;
        @(posedge clk);
        if (clear_i) model_reset();
        else begin
            if (slv_r_valid && n == 0) m_err = 1;
            if (pop) void'(q.pop_front());
            m_hs = e_req && slv_gnt;
            if (m_hs) begin
                q.push_back(sel);
                last = sel;
            end
            held = (e_req && !slv_gnt) ? sel : -1;
        end
        @(negedge clk);
    endtask

    initial begin
        rst_ni = 1'b0; clear_i = 1'b0;
        mst_req = '0; mst_wen = '0; mst_add = '0; mst_data = '0; mst_be = '0;
        slv_gnt = 1'b0; slv_r_valid = 1'b0; slv_r_data = '0;
        model_reset();
        #1;
        chk("rst_err", err_o, 1'b0);
        mst_req = '1; slv_gnt = 1'b1; slv_r_valid = 1'b1;
        #1;
        chk("rst_slv_req", slv_req, 1'b0);
        chk("rst_gnt", mst_gnt, '0);
        chk("rst_r_valid", mst_r_valid, '0);
        @(negedge clk);
        slv_r_valid = 1'b0; mst_req = '0;
        rst_ni = 1'b1;

        // Round-robin order with a one-cycle memory
        for (int i = 0; i < 6; i++) begin
            mst_req = 3'b111; mst_wen = 3'b111; slv_gnt = 1'b1;
            for (int m = 0; m < MP; m++) mst_add[m] = 32'h1000 * (m + 1) + i;
            slv_r_valid = m_hs; slv_r_data = $urandom;
            step();
            chk("rr_order", obs_gnt, 3'b001 << (i % 3));
        end
        mst_req = '0; slv_r_valid = m_hs; slv_r_data = $urandom;
        step();
        slv_r_valid = 1'b0;

        // Stalled grant holds master 2 although master 0 joins
        clear_i = 1'b1; step(); clear_i = 1'b0;
        mst_req = 3'b100; mst_wen = 3'b100; mst_add[2] = 32'h100; mst_add[0] = 32'h200;
        slv_gnt = 1'b0;
        step();
        chk("stall_c1", obs_gnt, 3'b000);
        mst_req = 3'b101;
        step();
        step();
        chk("stall_c3_req", obs_req, 1'b1);
        slv_gnt = 1'b1;
        step();
        chk("stall_grant2", obs_gnt, 3'b100);
        chk("stall_add", obs_add, 32'h100);
        mst_req = 3'b001;
        step();
        chk("stall_grant0", obs_gnt, 3'b001);
        mst_req = '0; slv_r_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin slv_r_data = $urandom; step(); end
        slv_r_valid = 1'b0;

        // Outstanding limit and push-with-pop when full
        clear_i = 1'b1; step(); clear_i = 1'b0;
        mst_req = 3'b111; slv_gnt = 1'b1;
        for (int i = 0; i < 4; i++) step();
        step();
        chk("full_block", obs_req, 1'b0);
        slv_r_valid = 1'b1; slv_r_data = 32'hCAFE0001;
        step();
        chk("full_pop_req", obs_req, 1'b1);
        chk("full_pop_gnt", obs_gnt, 3'b010);
        mst_req = '0;
        for (int i = 0; i < 4; i++) begin slv_r_data = $urandom; step(); end
        slv_r_valid = 1'b0;

        // Response with nothing outstanding
        slv_r_valid = 1'b1; slv_r_data = 32'hDEAD;
        step();
        slv_r_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("err_sticky", err_o, 1'b1);
        clear_i = 1'b1; step(); clear_i = 1'b0;
        step();
        chk("err_cleared", err_o, 1'b0);

        // Asynchronous reset with two transactions in flight
        mst_req = 3'b111; slv_gnt = 1'b1;
        step(); step();
        #2 rst_ni = 1'b0; slv_r_valid = 1'b1;
        #1;
        chk("arst_slv_req", slv_req, 1'b0);
        chk("arst_gnt", mst_gnt, '0);
        chk("arst_r_valid", mst_r_valid, '0);
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1; slv_r_valid = 1'b0;
        step();
        chk("arst_restart", obs_gnt, 3'b001);
        mst_req = '0; slv_r_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin slv_r_data = $urandom; step(); end
        slv_r_valid = 1'b0;
        chk("arst_late_err", err_o, 1'b1);

        // Randomized traffic
        clear_i = 1'b1; step(); clear_i = 1'b0;
        for (int i = 0; i < 400; i++) begin
            mst_req = MP'($urandom); mst_wen = MP'($urandom);
            for (int m = 0; m < MP; m++) begin
                mst_add[m] = $urandom; mst_data[m] = $urandom; mst_be[m] = 4'($urandom);
            end
            slv_gnt = ($urandom_range(0, 3) != 0);
            slv_r_valid = (q.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 40) == 0);
            slv_r_data = $urandom;
            clear_i = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
